// File: rtl/dac_sample_scheduler.sv
// Paces samples from two requesters into a 12-bit SPI DAC serializer on a
// fixed slot grid, with round-robin arbitration, underrun repeat and handshake supervision.
module dac_sample_scheduler #(
  parameter int unsigned SAMPLE_DIV   = 480,
  parameter bit          REPEAT_LAST  = 1'b1,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic        clk12MHz,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [11:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [11:0] req1_data,
  output logic        req1_ready,
  output logic [11:0] dac_value,
  output logic        dac_start,
  input  logic        dac_busy,
  output logic [1:0]  grant,
  output logic [7:0]  underrun_cnt,
  output logic        overrun,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(SAMPLE_DIV);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_START     = 2'd1;
  localparam logic [1:0] S_WAIT_BUSY = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  logic [CNT_W-1:0] slot_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [1:0]       state;
  logic             prio1;
  logic             tick;
  logic             slot_open;
  logic             pick1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Slot grid runs freely regardless of what the transfer FSM is doing
  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
    end else if (slot_cnt == CNT_LAST) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign tick      = (slot_cnt == CNT_LAST);
  assign slot_open = (state == S_IDLE) && tick;
  // prio1 set means requester 1 was not granted last and wins a tie
  assign pick1      = req1_valid && (!req0_valid || prio1);
  assign req0_ready = slot_open && req0_valid && !pick1;
  assign req1_ready = slot_open && pick1;
  assign dac_start  = (state == S_START);

  always_ff @(posedge clk12MHz or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      tmo_cnt      <= '0;
      prio1        <= 1'b0;
      dac_value    <= 12'h000;
      grant        <= 2'b00;
      underrun_cnt <= 8'h00;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (tick && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (tick) begin
            if (req0_ready) begin
              dac_value <= req0_data;
              grant     <= 2'b01;
              prio1     <= 1'b1;
              state     <= S_START;
            end else if (req1_ready) begin
              dac_value <= req1_data;
              grant     <= 2'b10;
              prio1     <= 1'b0;
              state     <= S_START;
            end else begin
              underrun_cnt <= sat_inc8(underrun_cnt);
              if (REPEAT_LAST) begin
                grant <= 2'b00;
                state <= S_START;
              end
            end
          end
        end
        S_START: begin
          tmo_cnt <= '0;
          state   <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (dac_busy) begin
            state <= S_WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!dac_busy) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Randomised and directed bench for dac_sample_scheduler against a slot/transfer timing model.
module tb_dac_sample_scheduler;
  localparam int DIV = 8;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [11:0] req0_data = 12'h0, req1_data = 12'h0;
  logic        req0_ready, req1_ready;
  logic [11:0] dac_value;
  logic        dac_start;
  logic        dac_busy;
  logic [1:0]  grant;
  logic [7:0]  underrun_cnt;
  logic        overrun, timeout_err;

  dac_sample_scheduler #(.SAMPLE_DIV(DIV), .REPEAT_LAST(1'b1), .BUSY_TIMEOUT(TMO)) dut (
    .clk12MHz(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .dac_value(dac_value), .dac_start(dac_start), .dac_busy(dac_busy),
    .grant(grant), .underrun_cnt(underrun_cnt), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Serializer model: busy rises busy_dly cycles into the handshake wait, stays up busy_len cycles
  int busy_dly = 0, busy_len = 4;
  bit busy_never = 1'b0;
  initial begin
    int pend, left;
    logic s;
    dac_busy = 1'b0; pend = -1; left = 0;
    forever begin
      @(negedge clk); s = dac_start;
      @(posedge clk); #2;
      if (rst) begin
        dac_busy = 1'b0; pend = -1; left = 0;
      end else begin
        if (dac_busy) begin left--; if (left <= 0) dac_busy = 1'b0; end
        if (s && !busy_never) pend = busy_dly;
        if (pend == 0) begin dac_busy = 1'b1; left = busy_len; end
        if (pend >= 0) pend--;
      end
    end
  end

  // Records shared with the stimulus (written only here)
  int cyc = 0, first_ready_cyc = -1, first_start_cyc = -1, n_starts = 0;
  logic [11:0] log_v [0:4095];
  logic [1:0]  log_g [0:4095];

  // Behavioural model + per-cycle compare, evaluated at the falling edge
  initial begin
    int m_pos, m_since, m_under, winner;
    bit m_inflight, m_busy_seen, m_over, m_tmo, m_prio1, tick, launch;
    logic [11:0] m_val;
    logic [1:0]  m_grant;
    m_pos = 0; m_since = 0; m_under = 0; m_inflight = 0; m_busy_seen = 0;
    m_over = 0; m_tmo = 0; m_prio1 = 0; m_val = 12'h0; m_grant = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pos = 0; m_since = 0; m_under = 0; m_inflight = 0; m_busy_seen = 0;
        m_over = 0; m_tmo = 0; m_prio1 = 0; m_val = 12'h0; m_grant = 2'b00;
        cyc = 0; first_ready_cyc = -1; first_start_cyc = -1;
      end
      tick = !rst && (m_pos == DIV - 1);
      winner = -1;
      if (tick && !m_inflight) begin
        if (req0_valid && req1_valid) winner = m_prio1 ? 1 : 0;
        else if (req0_valid) winner = 0;
        else if (req1_valid) winner = 1;
      end
      chk("req0_ready", req0_ready, winner == 0);
      chk("req1_ready", req1_ready, winner == 1);
      chk("dac_start", dac_start, m_inflight && m_since == 0);
      chk("dac_value", dac_value, m_val);
      chk("grant", grant, m_grant);
      chk("underrun_cnt", underrun_cnt, m_under);
      chk("overrun", overrun, m_over);
      chk("timeout_err", timeout_err, m_tmo);
      if (!rst) begin
        if (req0_ready && first_ready_cyc < 0) first_ready_cyc = cyc;
        if (dac_start) begin
          if (first_start_cyc < 0) first_start_cyc = cyc;
          log_v[n_starts % 4096] = dac_value;
          log_g[n_starts % 4096] = grant;
          n_starts++;
        end
        cyc++;
        launch = 0;
        if (tick) begin
          if (m_inflight) m_over = 1;
          else launch = 1;
        end
        if (m_inflight) begin
          if (m_since == 0) m_since = 1;
          else if (!m_busy_seen) begin
            if (dac_busy) m_busy_seen = 1;
            else if (m_since == TMO) begin m_tmo = 1; m_inflight = 0; end
            else m_since++;
          end else if (!dac_busy) m_inflight = 0;
        end
        if (launch) begin
          if (winner == 0) begin m_val = req0_data; m_grant = 2'b01; m_prio1 = 1; end
          else if (winner == 1) begin m_val = req1_data; m_grant = 2'b10; m_prio1 = 0; end
          else begin m_grant = 2'b00; if (m_under < 255) m_under++; end
          m_inflight = 1; m_since = 0; m_busy_seen = 0;
        end
        m_pos = (m_pos + 1) % DIV;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; step(3); rst = 1'b0;
  endtask

  // Returns at falling edge + 1 once n_starts reaches target, or flags an expired bound
  task automatic wait_starts(input int target, input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge clk); #1;
      if (n_starts >= target) break;
    end
    if (k == bound) chk("wait_dac_start_bound", n_starts, target);
  endtask

  initial begin
    int base, k;
    logic [1:0]  g3 [0:2];
    logic [11:0] v3 [0:2];
    g3[0] = 2'b01; g3[1] = 2'b10; g3[2] = 2'b01;
    v3[0] = 12'h111; v3[1] = 12'h222; v3[2] = 12'h111;

    step(2);
    @(negedge clk); #1;
    chk("reset_dac_value", dac_value, 12'h000);
    chk("reset_grant", grant, 2'b00);
    chk("reset_underrun", underrun_cnt, 8'h00);

    // First slot after reset with a single requester
    req0_valid = 1'b1; req0_data = 12'hABC;
    do_reset();
    wait_starts(n_starts + 1, 40);
    chk("first_ready_cycle", first_ready_cyc, 7);
    chk("first_start_cycle", first_start_cyc, 8);
    chk("first_value", dac_value, 12'hABC);
    chk("first_grant", grant, 2'b01);

    // Round-robin between two requesters
    step(1);
    req1_valid = 1'b1; req0_data = 12'h111; req1_data = 12'h222;
    do_reset();
    base = n_starts;
    wait_starts(base + 3, 60);
    for (int i = 0; i < 3; i++) begin
      chk("rr_grant", log_g[(base + i) % 4096], g3[i]);
      chk("rr_value", log_v[(base + i) % 4096], v3[i]);
    end

    // Repeat before any sample, then after one sample, through saturation
    step(1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    do_reset();
    wait_starts(n_starts + 1, 40);
    chk("repeat_initial_value", dac_value, 12'h000);
    chk("repeat_initial_grant", grant, 2'b00);
    chk("repeat_initial_underrun", underrun_cnt, 8'd1);
    step(1);
    req0_valid = 1'b1; req0_data = 12'h5A5;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (req0_ready) break;
    end
    if (k == 40) chk("wait_ready_bound", req0_ready, 1'b1);
    step(1);
    req0_valid = 1'b0;
    step(300 * DIV);
    @(negedge clk); #1;
    chk("sat_underrun", underrun_cnt, 8'd255);
    chk("sat_value", dac_value, 12'h5A5);
    chk("sat_last_logged", log_v[(n_starts - 1) % 4096], 12'h5A5);
    chk("sat_last_grant", log_g[(n_starts - 1) % 4096], 2'b00);

    // Busy outlasting a slot
    step(1);
    busy_len = 12; req0_valid = 1'b1; req0_data = 12'h3C3;
    wait_starts(n_starts + 1, 40);
    step(10);
    chk("overrun_set", overrun, 1'b1);
    busy_len = 4;
    wait_starts(n_starts + 1, 40);

    // Busy never rises
    step(1);
    busy_never = 1'b1; req0_data = 12'h777;
    do_reset();
    wait_starts(n_starts + 1, 40);
    step(6);
    chk("timeout_set", timeout_err, 1'b1);
    busy_never = 1'b0;
    base = n_starts;
    wait_starts(base + 1, 40);
    chk("after_timeout_grant", grant, 2'b01);
    chk("after_timeout_value", dac_value, 12'h777);

    // Reset while the serializer is busy
    step(1);
    busy_len = 12; req0_data = 12'h1AB;
    do_reset();
    wait_starts(n_starts + 1, 40);
    step(4);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_value", dac_value, 12'h000);
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_start", dac_start, 1'b0);
    step(2);
    rst = 1'b0;
    wait_starts(n_starts + 1, 40);
    chk("midrst_first_start", first_start_cyc, 8);
    busy_len = 4;

    // Random traffic, serializer behaviour and occasional resets
    for (int c = 0; c < 400 * DIV; c++) begin
      step(1);
      req0_valid = ($urandom % 3) != 0;
      req1_valid = ($urandom % 3) != 0;
      req0_data  = 12'($urandom);
      req1_data  = 12'($urandom);
      busy_dly   = $urandom_range(0, 5);
      busy_len   = $urandom_range(1, 14);
      busy_never = ($urandom % 10) == 0;
      if (rst) rst = 1'b0;
      else if (($urandom % 500) == 0) rst = 1'b1;
    end
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
